// File: rtl/button_light_ctrl.sv
// Push-button light controller. The raw button goes through a two-flop
// synchronizer and a four-state debouncer. Each accepted press toggles the
// light, and an optional timer turns the light off automatically.
// force_off overrides everything else on the light path.
module button_light_ctrl #(
    parameter int DB_CYCLES      = 4,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    input  logic force_off,
    output logic light,
    output logic btn_db,
    output logic press_pulse,
    output logic timeout_pulse
);

    localparam int              CW       = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DB_CYCLES - 1);
    localparam logic [23:0]     TMR_LAST = 24'(TIMEOUT_CYCLES - 1);
    localparam bit              TMR_EN   = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        WAIT_HI   = 2'd1,
        STABLE_HI = 2'd2,
        WAIT_LO   = 2'd3
    } db_state_t;

    db_state_t      state, state_nxt;
    logic [CW-1:0]  cnt, cnt_nxt;
    logic           s1, s2;
    logic           rise;
    logic           expire;
    logic [23:0]    tmr;

    // Two-flop synchronizer for the asynchronous button level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= btn;
            s2 <= s1;
        end
    end

    // Debouncer state and persistence counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= STABLE_LO;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Debouncer next state: a change must persist DB_CYCLES samples.
    // Reverting to the stable level while waiting drops back silently.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rise      = 1'b0;
        case (state)
            STABLE_LO: begin
                if (s2) begin
                    state_nxt = WAIT_HI;
                    cnt_nxt   = CNT_ONE;
                end
            end
            WAIT_HI: begin
                if (!s2) begin
                    state_nxt = STABLE_LO;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = STABLE_HI;
                    cnt_nxt   = '0;
                    rise      = 1'b1;
                end else begin
                    cnt_nxt   = cnt + CNT_ONE;
                end
            end
            STABLE_HI: begin
                if (!s2) begin
                    state_nxt = WAIT_LO;
                    cnt_nxt   = CNT_ONE;
                end
            end
            WAIT_LO: begin
                if (s2) begin
                    state_nxt = STABLE_HI;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = STABLE_LO;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt   = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = STABLE_LO;
                cnt_nxt   = '0;
            end
        endcase
    end

    // The timer sits at TIMEOUT_CYCLES-1 on the edge that ends the on-period.
    assign expire = TMR_EN && light && (tmr == TMR_LAST);

    // Light, timer and strobes. Priority: force_off, then press, then timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            light         <= 1'b0;
            tmr           <= '0;
            btn_db        <= 1'b0;
            press_pulse   <= 1'b0;
            timeout_pulse <= 1'b0;
        end else begin
            btn_db        <= (state_nxt == STABLE_HI) || (state_nxt == WAIT_LO);
            press_pulse   <= rise;
            timeout_pulse <= 1'b0;
            if (force_off) begin
                light <= 1'b0;
                tmr   <= '0;
            end else if (rise) begin
                light <= ~light;
                tmr   <= '0;
            end else if (expire) begin
                light         <= 1'b0;
                tmr           <= '0;
                timeout_pulse <= 1'b1;
            end else if (light) begin
                tmr <= tmr + 24'd1;
            end else begin
                tmr <= '0;
            end
        end
    end

endmodule

// File: tb/tb_button_light_ctrl.sv
// Bench for button_light_ctrl: a directed scenario set followed by randomized
// bouncing input. Two instances run side by side, one with a 20-cycle timeout
// and one with the timeout disabled. A behavioural model predicts every output.
module tb_button_light_ctrl;

    localparam int DB  = 4;
    localparam int TOA = 20;

    logic clk;
    logic rst_n;
    logic btn;
    logic force_off;
    logic light_a, btn_db_a, press_pulse_a, timeout_pulse_a;
    logic light_b, btn_db_b, press_pulse_b, timeout_pulse_b;

    int n_tests = 0;
    int n_fail  = 0;

    button_light_ctrl #(.DB_CYCLES(DB), .TIMEOUT_CYCLES(TOA)) dut_a (
        .clk(clk), .rst_n(rst_n), .btn(btn), .force_off(force_off),
        .light(light_a), .btn_db(btn_db_a),
        .press_pulse(press_pulse_a), .timeout_pulse(timeout_pulse_a)
    );

    button_light_ctrl #(.DB_CYCLES(DB), .TIMEOUT_CYCLES(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .btn(btn), .force_off(force_off),
        .light(light_b), .btn_db(btn_db_b),
        .press_pulse(press_pulse_b), .timeout_pulse(timeout_pulse_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: the button is seen two samples late; a level is
    // accepted once it has differed from the debounced level for DB samples
    // in a row. Light on-time is counted in cycles and capped at the timeout.
    int m_to [2] = '{TOA, 0};
    bit m_q1, m_q2, m_db, m_pp;
    int m_run;
    bit m_light [2];
    bit m_tp    [2];
    int m_on    [2];

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q1 = 0; m_q2 = 0; m_db = 0; m_pp = 0; m_run = 0;
        for (int k = 0; k < 2; k++) begin
            m_light[k] = 0; m_tp[k] = 0; m_on[k] = 0;
        end
    endtask

    task automatic model_edge();
        bit seen, rise;
        if (!rst_n) begin
            model_reset();
            return;
        end
        seen = m_q2;
        m_q2 = m_q1;
        m_q1 = btn;
        rise = 0;
        if (seen != m_db) begin
            m_run++;
            if (m_run >= DB) begin
                m_db  = seen;
                m_run = 0;
                rise  = seen;
            end
        end else begin
            m_run = 0;
        end
        m_pp = rise;
        for (int k = 0; k < 2; k++) begin
            m_tp[k] = 0;
            if (force_off) begin
                m_light[k] = 0;
                m_on[k]    = 0;
            end else if (rise) begin
                m_light[k] = !m_light[k];
                m_on[k]    = m_light[k] ? 1 : 0;
            end else if (m_light[k] && m_to[k] != 0 && m_on[k] >= m_to[k]) begin
                m_light[k] = 0;
                m_on[k]    = 0;
                m_tp[k]    = 1;
            end else if (m_light[k]) begin
                m_on[k]++;
            end
        end
    endtask

    task automatic compare_all();
        chk("light_a",  int'(light_a),         int'(m_light[0]));
        chk("light_b",  int'(light_b),         int'(m_light[1]));
        chk("btn_db_a", int'(btn_db_a),        int'(m_db));
        chk("btn_db_b", int'(btn_db_b),        int'(m_db));
        chk("press_a",  int'(press_pulse_a),   int'(m_pp));
        chk("press_b",  int'(press_pulse_b),   int'(m_pp));
        chk("tmo_a",    int'(timeout_pulse_a), int'(m_tp[0]));
        chk("tmo_b",    int'(timeout_pulse_b), int'(m_tp[1]));
    endtask

    // One clock: model advances with the edge, outputs checked half a cycle later.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Assert reset mid-cycle, confirm outputs clear at once, release after one edge.
    task automatic reset_pulse(input string tag);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk({tag, "_light_a"}, int'(light_a), 0);
        chk({tag, "_light_b"}, int'(light_b), 0);
        chk({tag, "_db"},      int'(btn_db_a), 0);
        chk({tag, "_press"},   int'(press_pulse_a), 0);
        chk({tag, "_tmo"},     int'(timeout_pulse_a), 0);
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        int cnt, pcnt, bound;
        bit any_db;
        rst_n = 1'b0;
        btn = 1'b0;
        force_off = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_light", int'(light_a), 0);
        chk("rst_db",    int'(btn_db_a), 0);
        chk("rst_press", int'(press_pulse_a), 0);
        chk("rst_tmo",   int'(timeout_pulse_a), 0);
        rst_n = 1'b1;
        steps(3);

        // Clean press: accepted on edge 6, strobe visible only in cycle 7.
        btn = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (i == 5) chk("clean_db_e5", int'(btn_db_a), 0);
            if (i == 6) begin
                chk("clean_db_e6",    int'(btn_db_a), 1);
                chk("clean_light_e6", int'(light_a), 1);
                chk("clean_press_c7", int'(press_pulse_a), 1);
            end
            if (i == 7) chk("clean_press_c8", int'(press_pulse_a), 0);
        end
        btn = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (i == 5) chk("rel_db_e5", int'(btn_db_a), 1);
            if (i == 6) begin
                chk("rel_db_e6",    int'(btn_db_a), 0);
                chk("rel_light_e6", int'(light_a), 1);
                chk("rel_press",    int'(press_pulse_a), 0);
            end
        end
        force_off = 1'b1; step(); force_off = 1'b0;

        // Bounce: short pulses never reach the debounced level.
        any_db = 0; pcnt = 0;
        btn = 1'b1; for (int i = 0; i < 2; i++) begin step(); any_db |= btn_db_a; end
        btn = 1'b0; step(); any_db |= btn_db_a;
        btn = 1'b1; for (int i = 0; i < 2; i++) begin step(); any_db |= btn_db_a; end
        btn = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            any_db |= btn_db_a;
            pcnt += int'(press_pulse_a);
        end
        chk("bounce_db",    int'(any_db), 0);
        chk("bounce_press", pcnt, 0);
        chk("bounce_light", int'(light_a), 0);

        // Auto-off: light on for exactly TOA cycles, one timeout strobe.
        btn = 1'b1; steps(6); btn = 1'b0;
        chk("auto_on", int'(light_a), 1);
        cnt = 1; bound = 0;
        while (light_a && bound < 40) begin
            step();
            bound++;
            if (light_a) cnt++;
        end
        chk("auto_on_cycles", cnt, TOA);
        chk("auto_tmo",       int'(timeout_pulse_a), 1);
        step();
        chk("auto_tmo_once",  int'(timeout_pulse_a), 0);
        cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            step();
            cnt += int'(light_b);
        end
        chk("no_timeout_hold", cnt, 1000);
        force_off = 1'b1; step(); force_off = 1'b0;
        steps(4);

        // Press accepted on the timer-expiry edge: toggles off, no timeout strobe.
        btn = 1'b1; steps(6);
        chk("coll_on", int'(light_a), 1);
        btn = 1'b0; steps(14);
        btn = 1'b1; steps(6);
        chk("coll_light", int'(light_a), 0);
        chk("coll_tmo",   int'(timeout_pulse_a), 0);
        chk("coll_press", int'(press_pulse_a), 1);
        step();
        chk("coll_tmo_late", int'(timeout_pulse_a), 0);
        btn = 1'b0; steps(10);

        // force_off on the acceptance edge: light stays off, press still strobes.
        btn = 1'b1; steps(5);
        force_off = 1'b1; step(); force_off = 1'b0;
        chk("fo_light_a", int'(light_a), 0);
        chk("fo_light_b", int'(light_b), 0);
        chk("fo_press",   int'(press_pulse_a), 1);
        chk("fo_db",      int'(btn_db_a), 1);
        btn = 1'b0; steps(10);

        // Reset while waiting to accept with the button still held.
        btn = 1'b1; steps(4);
        reset_pulse("midrst");
        for (int i = 1; i <= 6; i++) begin
            step();
            if (i == 5) chk("midrst_db_e5", int'(btn_db_a), 0);
            if (i == 6) begin
                chk("midrst_db_e6",    int'(btn_db_a), 1);
                chk("midrst_light_e6", int'(light_a), 1);
            end
        end
        btn = 1'b0; steps(10);
        force_off = 1'b1; step(); force_off = 1'b0;

        // Long hold toggles once; a second clean press toggles back.
        btn = 1'b1; pcnt = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            pcnt += int'(press_pulse_a);
        end
        chk("hold_press", pcnt, 1);
        chk("hold_light", int'(light_b), 1);
        btn = 1'b0; steps(10);
        btn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            pcnt += int'(press_pulse_a);
        end
        chk("double_press", pcnt, 2);
        chk("double_light", int'(light_b), 0);
        btn = 1'b0; steps(10);

        // Random bouncing levels with occasional force_off and reset.
        for (int n = 0; n < 4000; ) begin
            int len;
            btn = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 12));
            for (int j = 0; j < len; j++) begin
                force_off = ($urandom_range(0, 39) == 0);
                step();
                n++;
            end
            force_off = 1'b0;
            if ($urandom_range(0, 149) == 0) reset_pulse("rnd_rst");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
